ifu_fetch_queue: RTL and testbench

- Parametrised instruction fetch queue. Decouples the AXI fetch path from the ID stage.
- Accepts FETCH_NUM-wide fetch packets from the fetch/predecode path and stores individual instructions in a circular buffer.
- Presents up to ISSUE_NUM in-order instructions per cycle to ID.
- Generalises the fixed 2-wide, bufferless IF register stage:
  - configurable fetch width, issue width and depth;
  - partial-packet entry after a jump;
  - truncation after a predicted-taken branch;
  - per-instruction bus-error tagging.

---
 rtl/ifu_fetch_queue.sv | 141 ++++++++++++++
 tb/tb_ifu_fetch_queue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_queue.sv
// rtl/ifu_fetch_queue.sv - instruction fetch queue between the fetch path and ID
module ifu_fetch_queue #(
    parameter int INST_ADDR_WIDTH = 32,
    parameter int FETCH_NUM       = 2,
    parameter int ISSUE_NUM       = 2,
    parameter int DEPTH           = 8,
    localparam int OFF_W          = (FETCH_NUM > 1) ? $clog2(FETCH_NUM) : 1,
    localparam int PTR_W          = $clog2(DEPTH),
    localparam int CNT_W          = PTR_W + 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush_i,
    input  logic                               pkt_valid_i,
    output logic                               pkt_ready_o,
    input  logic [32*FETCH_NUM-1:0]            pkt_data_i,
    input  logic [INST_ADDR_WIDTH-1:0]         pkt_addr_i,
    input  logic [OFF_W-1:0]                   pkt_offset_i,
    input  logic [FETCH_NUM-1:0]               pkt_pred_i,
    input  logic                               pkt_err_i,
    output logic [ISSUE_NUM-1:0]               issue_valid_o,
    output logic [32*ISSUE_NUM-1:0]            issue_inst_o,
    output logic [INST_ADDR_WIDTH*ISSUE_NUM-1:0] issue_addr_o,
    output logic [ISSUE_NUM-1:0]               issue_pred_o,
    output logic [ISSUE_NUM-1:0]               issue_err_o,
    input  logic                               issue_ready_i,
    output logic [CNT_W-1:0]                   count_o
);

    logic [31:0]                inst_q [DEPTH];
    logic [31:0]                inst_d [DEPTH];
    logic [INST_ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [INST_ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic                       pred_q [DEPTH];
    logic                       pred_d [DEPTH];
    logic                       err_q  [DEPTH];
    logic                       err_d  [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             enq_fire;
    logic [CNT_W-1:0] n_enq;
    logic [CNT_W-1:0] n_avail;
    logic [CNT_W-1:0] n_deq;
    logic [PTR_W-1:0] wr_idx;
    logic             stop;
    logic [PTR_W-1:0] rd_idx;

    // Ready looks only at the registered count; a same-cycle dequeue earns no credit.
    assign pkt_ready_o = (count_q <= CNT_W'(DEPTH - FETCH_NUM));
    assign enq_fire    = pkt_valid_i && pkt_ready_o && !flush_i;
    assign n_avail     = (count_q < CNT_W'(ISSUE_NUM)) ? count_q : CNT_W'(ISSUE_NUM);
    assign n_deq       = issue_ready_i ? n_avail : '0;
    assign count_o     = count_q;

    // Slots before the offset or after the first predicted-taken slot are dropped;
    // surviving slots are packed contiguously starting at tail.
    always_comb begin
        inst_d = inst_q;
        addr_d = addr_q;
        pred_d = pred_q;
        err_d  = err_q;
        n_enq  = '0;
        stop   = 1'b0;
        wr_idx = tail_q;
        for (int k = 0; k < FETCH_NUM; k++) begin
            if ((k >= int'(pkt_offset_i)) && !stop) begin
                wr_idx = tail_q + n_enq[PTR_W-1:0];
                if (enq_fire) begin
                    inst_d[wr_idx] = pkt_data_i[32*k +: 32];
                    addr_d[wr_idx] = pkt_addr_i + INST_ADDR_WIDTH'(4 * k);
                    pred_d[wr_idx] = pkt_pred_i[k];
                    err_d[wr_idx]  = pkt_err_i;
                end
                n_enq = n_enq + CNT_W'(1);
                if (pkt_pred_i[k]) begin
                    stop = 1'b1;
                end
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + n_deq[PTR_W-1:0];
            if (enq_fire) begin
                tail_d = tail_q + n_enq[PTR_W-1:0];
            end
            count_d = count_q + (enq_fire ? n_enq : '0) - n_deq;
        end
    end

    // Invalid lanes are forced to zero so unreset storage never leaks out.
    always_comb begin
        issue_valid_o = '0;
        issue_inst_o  = '0;
        issue_addr_o  = '0;
        issue_pred_o  = '0;
        issue_err_o   = '0;
        rd_idx        = head_q;
        for (int i = 0; i < ISSUE_NUM; i++) begin
            rd_idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < n_avail) begin
                issue_valid_o[i]                                   = 1'b1;
                issue_inst_o[32*i +: 32]                           = inst_q[rd_idx];
                issue_addr_o[INST_ADDR_WIDTH*i +: INST_ADDR_WIDTH] = addr_q[rd_idx];
                issue_pred_o[i]                                    = pred_q[rd_idx];
                issue_err_o[i]                                     = err_q[rd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        inst_q <= inst_d;
        addr_q <= addr_d;
        pred_q <= pred_d;
        err_q  <= err_d;
    end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb/tb_ifu_fetch_queue.sv - directed vector bench for ifu_fetch_queue
module tb_ifu_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, pv, perr, rdy, pr;
    logic [63:0] pd;
    logic [31:0] pa;
    logic [0:0]  poff;
    logic [1:0]  ppred;
    logic [1:0]  iv, ip, ie;
    logic [63:0] ii, ia;
    logic [3:0]  cnt;

    logic         flush4, pv4, perr4, rdy4, pr4;
    logic [127:0] pd4;
    logic [31:0]  pa4;
    logic [1:0]   poff4;
    logic [3:0]   ppred4;
    logic [1:0]   iv4, ip4, ie4;
    logic [63:0]  ii4, ia4;
    logic [3:0]   cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifu_fetch_queue dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .pkt_valid_i(pv), .pkt_ready_o(pr), .pkt_data_i(pd), .pkt_addr_i(pa),
        .pkt_offset_i(poff), .pkt_pred_i(ppred), .pkt_err_i(perr),
        .issue_valid_o(iv), .issue_inst_o(ii), .issue_addr_o(ia),
        .issue_pred_o(ip), .issue_err_o(ie), .issue_ready_i(rdy), .count_o(cnt)
    );

    ifu_fetch_queue #(.FETCH_NUM(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush4),
        .pkt_valid_i(pv4), .pkt_ready_o(pr4), .pkt_data_i(pd4), .pkt_addr_i(pa4),
        .pkt_offset_i(poff4), .pkt_pred_i(ppred4), .pkt_err_i(perr4),
        .issue_valid_o(iv4), .issue_inst_o(ii4), .issue_addr_o(ia4),
        .issue_pred_o(ip4), .issue_err_o(ie4), .issue_ready_i(rdy4), .count_o(cnt4)
    );

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic [31:0] a;
        logic        off;
        logic [1:0]  pr;
        logic        er;
        logic        rdy;
        logic [3:0]  cnt;
        logic [1:0]  val;
        logic [31:0] a0, a1, i0, i1;
        logic [1:0]  err, pred;
        logic        prdy;
    } vec_t;

    vec_t vt [26];

    function automatic vec_t mk(input logic v, input logic [63:0] d, input logic [31:0] a,
                                input logic off, input logic [1:0] prd, input logic er,
                                input logic rd, input logic [3:0] c, input logic [1:0] val,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] i0, input logic [31:0] i1,
                                input logic [1:0] err, input logic [1:0] pred,
                                input logic prdy);
        vec_t r;
        r.v = v; r.d = d; r.a = a; r.off = off; r.pr = prd; r.er = er; r.rdy = rd;
        r.cnt = c; r.val = val; r.a0 = a0; r.a1 = a1; r.i0 = i0; r.i1 = i1;
        r.err = err; r.pred = pred; r.prdy = prdy;
        return r;
    endfunction

    function automatic logic [63:0] dw(input logic [31:0] a);
        return {a + 32'd4, a};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p, got, cyc;
        logic acc;

        rst_n = 1'b0; flush = 1'b0; pv = 1'b0; pd = '0; pa = '0; poff = '0;
        ppred = '0; perr = 1'b0; rdy = 1'b0;
        flush4 = 1'b0; pv4 = 1'b0; pd4 = '0; pa4 = '0; poff4 = '0;
        ppred4 = '0; perr4 = 1'b0; rdy4 = 1'b0;

        vt[0]  = mk(1, {32'h00B00093, 32'h00A00013}, 32'h100, 0, 2'b00, 0, 1, 2, 2'b11,
                    32'h100, 32'h104, 32'h00A00013, 32'h00B00093, 2'b00, 2'b00, 1);
        vt[1]  = mk(0, 64'h0, 32'h0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1);
        vt[2]  = mk(1, dw(32'h200), 32'h200, 1, 2'b00, 0, 0, 1, 2'b01,
                    32'h204, 0, 32'h204, 0, 2'b00, 2'b00, 1);
        vt[3]  = mk(0, 64'h0, 32'h0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1);
        vt[4]  = mk(1, dw(32'h400), 32'h400, 0, 2'b00, 0, 0, 2, 2'b11,
                    32'h400, 32'h404, 32'h400, 32'h404, 2'b00, 2'b00, 1);
        vt[5]  = mk(1, dw(32'h408), 32'h408, 0, 2'b00, 0, 0, 4, 2'b11,
                    32'h400, 32'h404, 32'h400, 32'h404, 2'b00, 2'b00, 1);
        vt[6]  = mk(1, dw(32'h410), 32'h410, 0, 2'b00, 0, 0, 6, 2'b11,
                    32'h400, 32'h404, 32'h400, 32'h404, 2'b00, 2'b00, 1);
        vt[7]  = mk(1, dw(32'h418), 32'h418, 0, 2'b00, 0, 0, 8, 2'b11,
                    32'h400, 32'h404, 32'h400, 32'h404, 2'b00, 2'b00, 0);
        vt[8]  = mk(1, dw(32'h420), 32'h420, 0, 2'b00, 0, 0, 8, 2'b11,
                    32'h400, 32'h404, 32'h400, 32'h404, 2'b00, 2'b00, 0);
        vt[9]  = mk(1, dw(32'h420), 32'h420, 0, 2'b00, 0, 1, 6, 2'b11,
                    32'h408, 32'h40C, 32'h408, 32'h40C, 2'b00, 2'b00, 1);
        vt[10] = mk(1, dw(32'h420), 32'h420, 0, 2'b00, 0, 0, 8, 2'b11,
                    32'h408, 32'h40C, 32'h408, 32'h40C, 2'b00, 2'b00, 0);
        vt[11] = mk(0, 64'h0, 32'h0, 0, 2'b00, 0, 1, 6, 2'b11,
                    32'h410, 32'h414, 32'h410, 32'h414, 2'b00, 2'b00, 1);
        vt[12] = mk(0, 64'h0, 32'h0, 0, 2'b00, 0, 1, 4, 2'b11,
                    32'h418, 32'h41C, 32'h418, 32'h41C, 2'b00, 2'b00, 1);
        vt[13] = mk(0, 64'h0, 32'h0, 0, 2'b00, 0, 1, 2, 2'b11,
                    32'h420, 32'h424, 32'h420, 32'h424, 2'b00, 2'b00, 1);
        vt[14] = mk(0, 64'h0, 32'h0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1);
        vt[15] = mk(1, dw(32'h500), 32'h500, 0, 2'b00, 1, 0, 2, 2'b11,
                    32'h500, 32'h504, 32'h500, 32'h504, 2'b11, 2'b00, 1);
        vt[16] = mk(0, 64'h0, 32'h0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1);
        vt[17] = mk(1, dw(32'h600), 32'h600, 0, 2'b01, 0, 0, 1, 2'b01,
                    32'h600, 0, 32'h600, 0, 2'b00, 2'b01, 1);
        vt[18] = mk(0, 64'h0, 32'h0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1);
        vt[19] = mk(1, dw(32'h610), 32'h610, 0, 2'b10, 0, 0, 2, 2'b11,
                    32'h610, 32'h614, 32'h610, 32'h614, 2'b00, 2'b10, 1);
        vt[20] = mk(0, 64'h0, 32'h0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1);
        vt[21] = mk(1, dw(32'h700), 32'h700, 1, 2'b01, 0, 0, 1, 2'b01,
                    32'h704, 0, 32'h704, 0, 2'b00, 2'b00, 1);
        vt[22] = mk(0, 64'h0, 32'h0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1);
        vt[23] = mk(1, dw(32'h800), 32'h800, 0, 2'b00, 0, 0, 2, 2'b11,
                    32'h800, 32'h804, 32'h800, 32'h804, 2'b00, 2'b00, 1);
        vt[24] = mk(1, dw(32'h808), 32'h808, 0, 2'b00, 0, 1, 2, 2'b11,
                    32'h808, 32'h80C, 32'h808, 32'h80C, 2'b00, 2'b00, 1);
        vt[25] = mk(0, 64'h0, 32'h0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1);

        #2;
        chk("rst_cnt", cnt, 0);
        chk("rst_valid", iv, 0);
        chk("rst_addr", ia, 0);
        chk("rst_inst", ii, 0);
        chk("rst_cnt4", cnt4, 0);
        tick();
        rst_n = 1'b1;
        chk("rst_ready", pr, 1);

        for (int i = 0; i < 26; i++) begin
            pv = vt[i].v; pd = vt[i].d; pa = vt[i].a; poff = vt[i].off;
            ppred = vt[i].pr; perr = vt[i].er; rdy = vt[i].rdy;
            tick();
            chk($sformatf("v%0d_cnt", i), cnt, vt[i].cnt);
            chk($sformatf("v%0d_valid", i), iv, vt[i].val);
            chk($sformatf("v%0d_addr", i), ia, {vt[i].a1, vt[i].a0});
            chk($sformatf("v%0d_inst", i), ii, {vt[i].i1, vt[i].i0});
            chk($sformatf("v%0d_err", i), ie, vt[i].err);
            chk($sformatf("v%0d_pred", i), ip, vt[i].pred);
            chk($sformatf("v%0d_ready", i), pr, vt[i].prdy);
        end

        // Wide-packet truncation on the FETCH_NUM=4 instance.
        pv4 = 1; pa4 = 32'h300; poff4 = 0; ppred4 = 4'b0010; rdy4 = 0;
        pd4 = {32'h30C, 32'h308, 32'h304, 32'h300};
        tick();
        chk("w4_cnt", cnt4, 2);
        chk("w4_valid", iv4, 2'b11);
        chk("w4_addr", ia4, {32'h304, 32'h300});
        chk("w4_pred", ip4, 2'b10);
        pv4 = 0; rdy4 = 1;
        tick();
        chk("w4_drain", cnt4, 0);
        pv4 = 1; pa4 = 32'h340; poff4 = 1; ppred4 = 4'b1000; rdy4 = 0;
        pd4 = {32'h34C, 32'h348, 32'h344, 32'h340};
        tick();
        chk("w4b_cnt", cnt4, 3);
        chk("w4b_addr", ia4, {32'h348, 32'h344});
        chk("w4b_inst", ii4, {32'h348, 32'h344});
        chk("w4b_pred", ip4, 2'b00);
        pv4 = 0; rdy4 = 1;
        tick();
        chk("w4b_cnt1", cnt4, 1);
        chk("w4b_valid1", iv4, 2'b01);
        chk("w4b_addr1", ia4, {32'h0, 32'h34C});
        chk("w4b_pred1", ip4, 2'b01);
        tick();
        chk("w4b_cnt0", cnt4, 0);
        rdy4 = 0;

        // Flush collides with an enqueue at count 5.
        rdy = 0; perr = 0; ppred = 0;
        pv = 1; poff = 1; pa = 32'h900; pd = dw(32'h900);
        tick();
        poff = 0; pa = 32'h908; pd = dw(32'h908);
        tick();
        pa = 32'h910; pd = dw(32'h910);
        tick();
        chk("fl_pre_cnt", cnt, 5);
        pa = 32'h918; pd = dw(32'h918); flush = 1; rdy = 1;
        tick();
        chk("fl_cnt", cnt, 0);
        chk("fl_valid", iv, 0);
        flush = 0; pv = 0; rdy = 0;
        tick();
        chk("fl_lost_cnt", cnt, 0);
        chk("fl_lost_valid", iv, 0);
        pv = 1; pa = 32'hA00; pd = dw(32'hA00); perr = 1;
        tick();
        chk("er_valid", iv, 2'b11);
        chk("er_err", ie, 2'b11);
        chk("er_addr", ia, {32'hA04, 32'hA00});
        pv = 0; perr = 0; flush = 1;
        tick();
        flush = 0;
        chk("fl2_cnt", cnt, 0);

        // Streaming across pointer wrap with toggling ready.
        p = 0; got = 0; cyc = 0;
        while (got < 40 && cyc < 300) begin
            pv = (p < 20);
            pa = 32'h1000 + 32'(8 * p);
            pd = dw(pa);
            rdy = cyc[0];
            acc = pv && pr;
            if (rdy) begin
                for (int l = 0; l < 2; l++) begin
                    if (iv[l]) begin
                        chk($sformatf("st_addr%0d", got), ia[32*l +: 32], 32'h1000 + 32'(4 * got));
                        chk($sformatf("st_inst%0d", got), ii[32*l +: 32], 32'h1000 + 32'(4 * got));
                        got++;
                    end
                end
            end
            tick();
            if (acc) p++;
            cyc++;
        end
        chk("st_count", got, 40);
        chk("st_pkts", p, 20);
        pv = 0; rdy = 0;
        tick();
        chk("st_empty", cnt, 0);

        // Asynchronous reset in the middle of operation.
        pv = 1; pa = 32'hB00; pd = dw(32'hB00);
        tick();
        pv = 0;
        chk("ar_pre_cnt", cnt, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_cnt", cnt, 0);
        chk("ar_valid", iv, 0);
        chk("ar_addr", ia, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_post_cnt", cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
